// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary to packed BCD converter
// Ports: clk clock, rst sync active-high reset, start/bin conversion request,
//        busy high while shifting, done one-cycle result strobe,
//        bcd packed result (digit 0 in [3:0]), ovf only with BIN_TO_BCD_OVF_EN defined.
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
`ifdef BIN_TO_BCD_OVF_EN
  ,
  output logic                ovf
`endif
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_scr;
  logic [BW-1:0]    r_bcd;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scr_nxt;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d+:4] = (r_scr[4*d+:4] >= 4'd5) ? r_scr[4*d+:4] + 4'd3 : r_scr[4*d+:4];
  end
  // The carry out of the top digit is dropped, which leaves the result modulo 10^DIGITS.
  assign w_scr_nxt = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd       = r_bcd;
`ifdef BIN_TO_BCD_OVF_EN
  logic r_ovf_s;
  logic r_ovf;
  assign ovf = r_ovf;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_adj[BW-1];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
`ifdef BIN_TO_BCD_OVF_EN
      r_ovf_s <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == SHIFT) begin
      r_scr <= w_scr_nxt;
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + CW'(1);
`ifdef BIN_TO_BCD_OVF_EN
      r_ovf_s <= r_ovf_s | w_adj[BW-1];
`endif
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_bcd   <= w_scr_nxt;
`ifdef BIN_TO_BCD_OVF_EN
        r_ovf   <= r_ovf_s | w_adj[BW-1];
`endif
      end
    end else if (start) begin
      r_state <= SHIFT;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_bin   <= bin;
      r_scr   <= '0;
      r_cnt   <= '0;
`ifdef BIN_TO_BCD_OVF_EN
      r_ovf_s <= 1'b0;
`endif
    end else begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: scoreboard bench for bin_to_bcd (3-digit and 2-digit instances in lockstep)
module tb_bin_to_bcd;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        busy, done, busy2, done2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;
`ifdef BIN_TO_BCD_OVF_EN
  logic        ovf, ovf2;
`endif
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  typedef struct {int v; int c;} item_t;
  item_t sb[$];
  logic [11:0] hold1 = '0;
  logic [7:0]  hold2 = '0;
  bit          jitter = 1'b0;
  int          dir[8] = '{0, 255, 99, 100, 1, 9, 10, 200};

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN_TO_BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2)
`ifdef BIN_TO_BCD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v, input int d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [63:0] b, input int d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < d; i++) if (b[4*i+:4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Drive one request at a negedge where the DUT is idle or done; returns at the done-cycle negedge.
  task automatic go(input int v);
    start = 1'b1;
    bin   = 8'(v);
    sb.push_back('{v, cyc});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("busy_in_shift", busy, 1);
      check("bcd_hold", bcd, hold1);
      check("bcd2_hold", bcd2, hold2);
      if (jitter) begin
        start = 1'($urandom);
        bin   = 8'($urandom);
      end else start = 1'b0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done || done2) begin
      item_t it;
      check("done_align", done2, done);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        it = sb.pop_front();
        check("latency", cyc - it.c, 9);
        check("bcd", bcd, to_bcd(it.v, 3));
        check("bcd2", bcd2, to_bcd(it.v, 2));
`ifdef BIN_TO_BCD_OVF_EN
        check("ovf", ovf, 0);
        check("ovf2", ovf2, it.v >= 100);
`endif
        hold1 = 12'(to_bcd(it.v, 3));
        hold2 = 8'(to_bcd(it.v, 2));
      end
      check("digits", digits_ok(bcd, 3), 1);
      check("digits2", digits_ok(bcd2, 2), 1);
      check("busy_at_done", busy, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_bcd2", bcd2, 0);
`ifdef BIN_TO_BCD_OVF_EN
    check("rst_ovf2", ovf2, 0);
`endif
    start = 1'b1;
    bin   = 8'd255;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    foreach (dir[k]) begin
      go(dir[k]);
      start = 1'b0;
      @(negedge clk);
      check("done_single", done, 0);
      check("busy_idle", busy, 0);
      check("bcd_after_done", bcd, hold1);
    end
    jitter = 1'b1;
    go(37);
    go(200);
    start  = 1'b0;
    jitter = 1'b0;
    @(negedge clk);
    check("b2b_done_end", done, 0);
    start = 1'b1;
    bin   = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd, 0);
    check("abort_bcd2", bcd2, 0);
    hold1 = '0;
    hold2 = '0;
    rst = 1'b0;
    go(42);
    start = 1'b0;
    @(negedge clk);
    jitter = 1'b1;
    for (int v = 0; v < 256; v++) go(v);
    start  = 1'b0;
    jitter = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
